udp_instr_rx: RTL and testbench
===============================

Name: udp_instr_rx

Overview:
Receive-side instruction decoder for the UDP instruction port. It is the peer of the instruction transmit path.
- Input: the UDP payload byte stream already extracted by the RX UDP/IP stack.
- Function: frames and checksums instruction packets, then publishes each accepted command.
- Outputs: applies LED and digit-LED commands directly to the led_data and dled registers at top level.

Parameters:
- MAX_LEN, 16: maximum payload length in bytes. A larger LEN is an error.
- HDR0, 8'hA5: first header byte.
- HDR1, 8'h5A: second header byte.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_data  in  8  UDP payload byte.
- rx_last  in  1  marks the last payload byte of the datagram. Only meaningful when rx_valid=1.
- cmd_valid  out  1  one-cycle pulse for each accepted frame.
- cmd_code  out  8  CMD byte of the last accepted frame.
- cmd_len  out  8  LEN byte of the last accepted frame.
- cmd_arg  out  16  first two payload bytes, {p0,p1}. Missing bytes read as 0.
- led_data  out  4  LED register.
- dled  out  16  digit-LED register.
- frame_cnt  out  8  accepted-frame counter. Saturates at 255.
- err_cnt  out  8  error counter. Saturates at 255.

Behaviour:
- Frame format, one frame per datagram: HDR0 HDR1 CMD LEN P[0..LEN-1] CHK.
  - CHK = (CMD + LEN + sum of P) mod 256.
- Reset (rst_n=0 at a clk edge): every output goes to 0 and the FSM goes to IDLE. This applies mid-frame as well; the partial frame is discarded and not counted.
- State only advances on cycles with rx_valid=1. Gaps with rx_valid=0 hold all state.
- FSM states: IDLE, H1, CMD, LEN, PAY, CHK, DROP.
  - IDLE (datagram start):
    - byte==HDR0 and !last: go to H1.
    - byte!=HDR0 and !last: go to DROP silently (foreign datagram, no error).
    - any byte with last: stay in IDLE, no error.
  - H1:
    - byte==HDR1: go to CMD.
    - otherwise: error. Go to DROP, or to IDLE if last.
  - CMD: latch cmd_r, set sum=byte, clear arg_r to 0, go to LEN.
  - LEN: latch len_r, sum+=byte.
    - LEN>MAX_LEN: error, go to DROP (IDLE if last).
    - LEN==0: go to CHK.
    - otherwise: go to PAY.
  - PAY:
    - sum+=byte.
    - idx0 goes to arg_r[15:8]; idx1 goes to arg_r[7:0]; later bytes go to the checksum only.
    - idx counter is 8 bits and is cleared on entry.
    - When idx==len_r-1, go to CHK.
  - CHK:
    - byte==sum and last: accept, go to IDLE.
    - byte!=sum: error.
    - byte==sum but !last: error (trailing bytes).
    - On error, go to DROP, or to IDLE if last.
  - DROP: discard bytes until a byte with last, then go to IDLE. No further error counted.
- Truncation: last asserted in H1, CMD, LEN or PAY (before the final payload byte is consumed and CHK is reached) is one error, then go to IDLE.
- Each bad frame counts at most one error.
- Accept, registered on the edge following the CHK byte cycle:
  - cmd_valid=1 for exactly 1 cycle.
  - cmd_code, cmd_len and cmd_arg are updated together and held until the next accept.
  - frame_cnt+1.
  - CMD 8'h01: led_data <= arg_r[3:0], same cycle as cmd_valid.
  - CMD 8'h02: dled <= arg_r, same cycle as cmd_valid.
  - Any other CMD: only cmd_valid and the cmd_* outputs change.
- Errors: err_cnt+1 on the edge after the offending byte. Never wraps. cmd_* outputs, led_data and dled are unchanged.
- Back-to-back datagrams are allowed: IDLE can accept HDR0 on the cycle right after an accept or a last byte.
- Arithmetic: sum is 8 bits and wraps mod 256. Counters stick at 8'hFF.

Test Plan:
- LED command: A5 5A 01 02 00 0C 0F(last), contiguous.
  - cmd_valid high 1 cycle, one clk after the 0F byte.
  - cmd_code=01, cmd_len=02, cmd_arg=000C, led_data=C, frame_cnt=1, err_cnt=0.
- Digit-LED command with gaps: A5 5A 02 02 12 34 4A(last), with 1–3 rx_valid=0 cycles between bytes.
  - dled=16'h1234, cmd_arg=1234, frame_cnt=1; same results as the contiguous case.
- Bad checksum: A5 5A 01 02 00 0C 0E(last).
  - err_cnt=1, no cmd_valid, led_data unchanged.
  - A following valid LED frame is accepted, frame_cnt=1.
- Truncated frame: A5 5A 01 02 00(last), then LEN>MAX: A5 5A 01 11 … (last).
  - err_cnt=2, no cmd_valid; the bytes after 11 are dropped until last.
- Foreign datagram and trailing byte:
  - 45 A5 5A 01 00 01(last): dropped silently, err_cnt=0.
  - A5 5A 03 00 03 FF(last): err_cnt=1, no accept.
  - A5 5A 03 00 03(last): cmd_valid, cmd_code=03, cmd_arg=0000.
- Reset mid-frame: drop rst_n for 1 cycle after A5 5A 01.
  - All outputs are 0 the next cycle.
  - The remaining bytes 02 00 0C 0F(last) are dropped (the first byte is not A5); frame_cnt=0 and err_cnt=0.
  - A following full LED frame is accepted.

Source files
------------

// File: rtl/udp_instr_rx.sv
// Receive-side decoder for the UDP instruction port. It frames
// HDR0 HDR1 CMD LEN P[0..LEN-1] CHK packets from the payload byte
// stream, verifies the 8-bit additive checksum, and publishes each
// accepted command. LED and digit-LED commands are applied directly.
module udp_instr_rx #(
  parameter int          MAX_LEN = 16,
  parameter logic [7:0]  HDR0    = 8'hA5,
  parameter logic [7:0]  HDR1    = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [7:0]  cmd_len,
  output logic [15:0] cmd_arg,
  output logic [3:0]  led_data,
  output logic [15:0] dled,
  output logic [7:0]  frame_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0] CMD_LED   = 8'h01;
  localparam logic [7:0] CMD_DLED  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H1   = 3'd1,
    S_CMD  = 3'd2,
    S_LEN  = 3'd3,
    S_PAY  = 3'd4,
    S_CHK  = 3'd5,
    S_DROP = 3'd6
  } state_t;

  state_t      state;
  logic [7:0]  cmd_r;
  logic [7:0]  len_r;
  logic [7:0]  sum;
  logic [15:0] arg_r;
  logic [7:0]  idx;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Frame FSM, checksum accumulation, and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_r     <= 8'd0;
      len_r     <= 8'd0;
      sum       <= 8'd0;
      arg_r     <= 16'd0;
      idx       <= 8'd0;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'd0;
      cmd_len   <= 8'd0;
      cmd_arg   <= 16'd0;
      led_data  <= 4'd0;
      dled      <= 16'd0;
      frame_cnt <= 8'd0;
      err_cnt   <= 8'd0;
    end else begin
      cmd_valid <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            // A single-byte datagram is ignored; a foreign first byte
            // makes the whole datagram silently discarded.
            if (rx_last) begin
              state <= S_IDLE;
            end else if (rx_data == HDR0) begin
              state <= S_H1;
            end else begin
              state <= S_DROP;
            end
          end
          S_H1: begin
            if (rx_data == HDR1 && !rx_last) begin
              state <= S_CMD;
            end else begin
              // Bad second header byte or truncation: one error.
              err_cnt <= sat_inc(err_cnt);
              state   <= rx_last ? S_IDLE : S_DROP;
            end
          end
          S_CMD: begin
            cmd_r <= rx_data;
            sum   <= rx_data;
            arg_r <= 16'd0;
            if (rx_last) begin
              err_cnt <= sat_inc(err_cnt);
              state   <= S_IDLE;
            end else begin
              state <= S_LEN;
            end
          end
          S_LEN: begin
            len_r <= rx_data;
            sum   <= sum + rx_data;
            idx   <= 8'd0;
            if (rx_last) begin
              err_cnt <= sat_inc(err_cnt);
              state   <= S_IDLE;
            end else if (rx_data > MAX_LEN_B) begin
              err_cnt <= sat_inc(err_cnt);
              state   <= S_DROP;
            end else if (rx_data == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_PAY;
            end
          end
          S_PAY: begin
            sum <= sum + rx_data;
            idx <= idx + 8'd1;
            if (idx == 8'd0) begin
              arg_r[15:8] <= rx_data;
            end else if (idx == 8'd1) begin
              arg_r[7:0] <= rx_data;
            end else begin
              arg_r <= arg_r;
            end
            // Any last inside the payload leaves no room for CHK.
            if (rx_last) begin
              err_cnt <= sat_inc(err_cnt);
              state   <= S_IDLE;
            end else if (idx == len_r - 8'd1) begin
              state <= S_CHK;
            end else begin
              state <= S_PAY;
            end
          end
          S_CHK: begin
            if (rx_data == sum && rx_last) begin
              cmd_valid <= 1'b1;
              cmd_code  <= cmd_r;
              cmd_len   <= len_r;
              cmd_arg   <= arg_r;
              frame_cnt <= sat_inc(frame_cnt);
              case (cmd_r)
                CMD_LED:  led_data <= arg_r[3:0];
                CMD_DLED: dled     <= arg_r;
                default:  led_data <= led_data;
              endcase
              state <= S_IDLE;
            end else begin
              // Wrong checksum, or correct checksum followed by trailing bytes.
              err_cnt <= sat_inc(err_cnt);
              state   <= rx_last ? S_IDLE : S_DROP;
            end
          end
          S_DROP: begin
            state <= rx_last ? S_IDLE : S_DROP;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_instr_rx.sv
// Directed bench for udp_instr_rx. Stimulus pushes expected accepts
// into a scoreboard queue; a negedge monitor pops and compares on
// every cmd_valid pulse. Counters and registers are checked per frame.
module tb_udp_instr_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [7:0]  cmd_len;
  logic [15:0] cmd_arg;
  logic [3:0]  led_data;
  logic [15:0] dled;
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;

  udp_instr_rx dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_last(rx_last), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_len(cmd_len), .cmd_arg(cmd_arg), .led_data(led_data),
    .dled(dled), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  code;
    logic [7:0]  len;
    logic [15:0] arg;
    logic [3:0]  led;
    logic [15:0] dled;
    logic [7:0]  fc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  frm[$];
  bit          frm_last;
  logic [7:0]  e_fc, e_ec;
  logic [3:0]  e_led;
  logic [15:0] e_dled;
  logic        prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accept pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      chk("pulse_width", {31'd0, prev_valid}, 32'd0);
      if (sbq.size() == 0) begin
        chk("spurious_cmd_valid", 32'(sbq.size()), 32'd1);
      end else begin
        mon_e = sbq.pop_front();
        chk("cmd_code", cmd_code, mon_e.code);
        chk("cmd_len", cmd_len, mon_e.len);
        chk("cmd_arg", cmd_arg, mon_e.arg);
        chk("led_data", led_data, mon_e.led);
        chk("dled", dled, mon_e.dled);
        chk("frame_cnt_at_accept", frame_cnt, mon_e.fc);
      end
    end
    prev_valid = (cmd_valid === 1'b1);
  end

  // kind: 0 silently dropped / incomplete, 1 accepted, 2 one error.
  task automatic send(input int gap, input bit chain, input int kind,
                      input logic [7:0] code, input logic [7:0] len,
                      input logic [15:0] arg);
    if (kind == 1) begin
      e_fc = (e_fc == 8'hFF) ? e_fc : e_fc + 8'd1;
      if (code == 8'h01) e_led = arg[3:0];
      else if (code == 8'h02) e_dled = arg;
      sbq.push_back(exp_t'{code, len, arg, e_led, e_dled, e_fc});
    end else if (kind == 2) begin
      e_ec = (e_ec == 8'hFF) ? e_ec : e_ec + 8'd1;
    end
    for (int i = 0; i < frm.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = frm[i];
      rx_last  = frm_last && (i == frm.size() - 1);
      @(posedge clk); #1;
      if (gap > 0 && i < frm.size() - 1) begin
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        repeat (1 + (i % gap)) begin @(posedge clk); #1; end
      end
    end
    if (!chain) begin
      rx_valid = 1'b0;
      rx_last  = 1'b0;
    end
    @(negedge clk);
    chk("accept_pulse", {31'd0, cmd_valid}, (kind == 1) ? 32'd1 : 32'd0);
    chk("frame_cnt", frame_cnt, e_fc);
    chk("err_cnt", err_cnt, e_ec);
    chk("led_reg", led_data, e_led);
    chk("dled_reg", dled, e_dled);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    e_fc   = 8'd0;
    e_ec   = 8'd0;
    e_led  = 4'd0;
    e_dled = 16'd0;
    @(negedge clk);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd_code", cmd_code, 32'd0);
    chk("rst_cmd_len", cmd_len, 32'd0);
    chk("rst_cmd_arg", cmd_arg, 32'd0);
    chk("rst_led", led_data, 32'd0);
    chk("rst_dled", dled, 32'd0);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
    chk("sb_empty_at_reset", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; rx_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // LED command, contiguous
    frm = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h00, 8'h0C, 8'h0F}; frm_last = 1'b1;
    send(0, 1'b0, 1, 8'h01, 8'h02, 16'h000C);
    do_reset();

    // Digit-LED command with 1-3 idle cycles between bytes
    frm = '{8'hA5, 8'h5A, 8'h02, 8'h02, 8'h12, 8'h34, 8'h4A};
    send(3, 1'b0, 1, 8'h02, 8'h02, 16'h1234);
    do_reset();

    // Bad checksum, then a good LED frame
    frm = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h00, 8'h0C, 8'h0E};
    send(0, 1'b0, 2, 8'h00, 8'h00, 16'h0000);
    frm = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h00, 8'h0C, 8'h0F};
    send(0, 1'b0, 1, 8'h01, 8'h02, 16'h000C);
    do_reset();

    // Truncated payload, then LEN above maximum
    frm = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h00};
    send(0, 1'b0, 2, 8'h00, 8'h00, 16'h0000);
    frm = '{8'hA5, 8'h5A, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send(0, 1'b0, 2, 8'h00, 8'h00, 16'h0000);
    do_reset();

    // Foreign datagram, trailing byte after CHK, zero-length command
    frm = '{8'h45, 8'hA5, 8'h5A, 8'h01, 8'h00, 8'h01};
    send(0, 1'b0, 0, 8'h00, 8'h00, 16'h0000);
    frm = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h03, 8'hFF};
    send(0, 1'b0, 2, 8'h00, 8'h00, 16'h0000);
    frm = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h03};
    send(0, 1'b0, 1, 8'h03, 8'h00, 16'h0000);

    // Reset in the middle of a frame
    frm = '{8'hA5, 8'h5A, 8'h01}; frm_last = 1'b0;
    send(0, 1'b0, 0, 8'h00, 8'h00, 16'h0000);
    do_reset();
    frm = '{8'h02, 8'h00, 8'h0C, 8'h0F}; frm_last = 1'b1;
    send(0, 1'b0, 0, 8'h00, 8'h00, 16'h0000);
    frm = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h00, 8'h0C, 8'h0F};
    send(0, 1'b0, 1, 8'h01, 8'h02, 16'h000C);

    // Back-to-back: LEN == MAX_LEN, LEN == 1, checksum wrap
    frm = '{8'hA5, 8'h5A, 8'h02, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
            8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h9A};
    send(0, 1'b1, 1, 8'h02, 8'h10, 16'h0102);
    frm = '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h0B, 8'h0D};
    send(0, 1'b1, 1, 8'h01, 8'h01, 16'h0B00);
    frm = '{8'hA5, 8'h5A, 8'h02, 8'h02, 8'hFF, 8'hFF, 8'h02};
    send(0, 1'b0, 1, 8'h02, 8'h02, 16'hFFFF);
    frm = '{8'hA5, 8'h00};
    send(0, 1'b0, 2, 8'h00, 8'h00, 16'h0000);
    do_reset();

    // Counter saturation
    frm = '{8'hA5, 8'h5A, 8'h07, 8'h00, 8'h07};
    for (int k = 0; k < 260; k++) send(0, 1'b1, 1, 8'h07, 8'h00, 16'h0000);
    frm = '{8'hA5, 8'h00};
    for (int k = 0; k < 260; k++) send(0, 1'b0, 2, 8'h00, 8'h00, 16'h0000);
    chk("frame_cnt_sat", frame_cnt, 32'hFF);
    chk("err_cnt_sat", err_cnt, 32'hFF);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
